// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: word, opcode and byte-write mask, plus opcode
// classification helpers used by the MEM stage.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_wmask;

   typedef enum logic [3:0] {
      op_br   = 4'b0000,
      op_add  = 4'b0001,
      op_ldb  = 4'b0010,
      op_stb  = 4'b0011,
      op_jsr  = 4'b0100,
      op_and  = 4'b0101,
      op_ldr  = 4'b0110,
      op_str  = 4'b0111,
      op_rti  = 4'b1000,
      op_not  = 4'b1001,
      op_ldi  = 4'b1010,
      op_sti  = 4'b1011,
      op_jmp  = 4'b1100,
      op_shf  = 4'b1101,
      op_lea  = 4'b1110,
      op_trap = 4'b1111
   } lc3b_opcode;

   function automatic logic is_mem_op(input lc3b_opcode op);
      return op inside {op_ldr, op_str, op_ldb, op_stb, op_ldi, op_sti};
   endfunction

   function automatic logic is_byte_op(input lc3b_opcode op);
      return op inside {op_ldb, op_stb};
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Single-port data-memory request/response bus between the MEM stage
// controller (master) and the data memory (slave).
interface mem_stage_ctrl_if;
   import lc3b_types::*;

   logic          mem_read;
   logic          mem_write;
   lc3b_word      mem_address;
   lc3b_word      mem_wdata;
   lc3b_mem_wmask mem_byte_enable;
   logic          mem_resp;
   lc3b_word      mem_rdata;

   modport master (
      output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      input  mem_resp, mem_rdata
   );

   modport slave (
      input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
      output mem_resp, mem_rdata
   );
endinterface

// File: rtl/mem_byte_lane.sv
// Byte-lane steering for LDB/STB: lane mask, replicated store byte and
// sign-extended load byte. Word accesses pass through with both lanes.
module mem_byte_lane
   import lc3b_types::*;
(
   input  logic          i_byte,
   input  logic          i_addr0,
   input  lc3b_word      i_wdata,
   input  lc3b_word      i_rdata,
   output lc3b_mem_wmask o_byte_enable,
   output lc3b_word      o_wdata,
   output lc3b_word      o_rdata
);

   logic [7:0] w_rbyte;

   assign w_rbyte       = i_addr0 ? i_rdata[15:8] : i_rdata[7:0];
   assign o_byte_enable = i_byte ? (i_addr0 ? 2'b10 : 2'b01) : 2'b11;
   assign o_wdata       = i_byte ? {i_wdata[7:0], i_wdata[7:0]} : i_wdata;
   assign o_rdata       = i_byte ? {{8{w_rbyte[7]}}, w_rbyte} : i_rdata;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory sequencer: one instruction at a time, LDI/STI as two
// back-to-back accesses, Moore request outputs decoded from state and latches.
module mem_stage_ctrl
   import lc3b_types::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  lc3b_opcode         opcode,
   input  lc3b_word           addr,
   input  lc3b_word           wdata,
   mem_stage_ctrl_if.master   mem,
   output lc3b_word           rdata_out,
   output logic               ready
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_INDIRECT
   } state_e;

   state_e        r_state;
   lc3b_opcode    r_opcode;
   lc3b_word      r_addr;
   lc3b_word      r_wdata;
   lc3b_word      r_ptr;
   lc3b_word      r_rdata;

   logic          w_read;
   logic          w_write;
   lc3b_word      w_address;
   lc3b_word      w_wdata;
   lc3b_mem_wmask w_byte_enable;
   lc3b_mem_wmask w_lane_be;
   lc3b_word      w_lane_wdata;
   lc3b_word      w_rdata_ext;

   mem_byte_lane u_lane (
      .i_byte        (is_byte_op(r_opcode)),
      .i_addr0       (r_addr[0]),
      .i_wdata       (r_wdata),
      .i_rdata       (mem.mem_rdata),
      .o_byte_enable (w_lane_be),
      .o_wdata       (w_lane_wdata),
      .o_rdata       (w_rdata_ext)
   );

   // NOTE: state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_opcode <= op_br;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_ptr    <= '0;
         r_rdata  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && is_mem_op(opcode)) begin
                  r_opcode <= opcode;
                  r_addr   <= addr;
                  r_wdata  <= wdata;
                  r_state  <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (mem.mem_resp) begin
                  case (r_opcode)
                     op_ldi, op_sti: begin
                        r_ptr   <= {mem.mem_rdata[15:1], 1'b0};
                        r_state <= S_INDIRECT;
                     end
                     op_ldr: begin
                        r_rdata <= mem.mem_rdata;
                        r_state <= S_IDLE;
                     end
                     op_ldb: begin
                        r_rdata <= w_rdata_ext;
                        r_state <= S_IDLE;
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
            S_INDIRECT: begin
               if (mem.mem_resp) begin
                  if (r_opcode == op_ldi) r_rdata <= mem.mem_rdata;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      w_read        = 1'b0;
      w_write       = 1'b0;
      w_address     = '0;
      w_wdata       = '0;
      w_byte_enable = '0;
      case (r_state)
         S_ACCESS: begin
            w_read        = r_opcode inside {op_ldr, op_ldb, op_ldi, op_sti};
            w_write       = r_opcode inside {op_str, op_stb};
            w_address     = is_byte_op(r_opcode) ? r_addr : {r_addr[15:1], 1'b0};
            w_byte_enable = w_lane_be;
            w_wdata       = w_write ? w_lane_wdata : '0;
         end
         S_INDIRECT: begin
            w_read        = (r_opcode == op_ldi);
            w_write       = (r_opcode == op_sti);
            w_address     = r_ptr;
            w_byte_enable = 2'b11;
            w_wdata       = w_write ? r_wdata : '0;
         end
         default: ;
      endcase
   end

   assign mem.mem_read        = w_read;
   assign mem.mem_write       = w_write;
   assign mem.mem_address     = w_address;
   assign mem.mem_wdata       = w_wdata;
   assign mem.mem_byte_enable = w_byte_enable;
   assign rdata_out           = r_rdata;
   assign ready               = (r_state == S_IDLE);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, hand-written
// corner sequences and randomized transactions against a behavioural model.
module tb_mem_stage_ctrl;
   import lc3b_types::*;

   typedef struct {
      logic          rd;
      logic          wr;
      lc3b_word      ad;
      lc3b_mem_wmask be;
      lc3b_word      wd;
   } acc_t;

   typedef struct {
      lc3b_opcode op;
      lc3b_word   a;
      lc3b_word   wd;
      int         k1;
      lc3b_word   d1;
      int         k2;
      lc3b_word   d2;
      lc3b_word   exp_rdata;
      int         exp_low;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   lc3b_opcode opcode = op_br;
   lc3b_word   addr = '0;
   lc3b_word   wdata = '0;
   lc3b_word   rdata_out;
   logic       ready;

   mem_stage_ctrl_if mif ();

   mem_stage_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .opcode    (opcode),
      .addr      (addr),
      .wdata     (wdata),
      .mem       (mif),
      .rdata_out (rdata_out),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   int       checks = 0;
   int       errors = 0;
   acc_t     obs[4];
   int       obs_n;
   int       low_cnt;
   logic     unstable;
   lc3b_word m_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic acc_t cur_bus();
      acc_t c;
      c.rd = mif.mem_read;
      c.wr = mif.mem_write;
      c.ad = mif.mem_address;
      c.be = mif.mem_byte_enable;
      c.wd = mif.mem_wdata;
      return c;
   endfunction

   // Launch one instruction and act as the memory, answering access i after ki cycles.
   task automatic run_txn(input lc3b_opcode op, input lc3b_word a, input lc3b_word wd,
                          input int k1, input lc3b_word d1, input int k2, input lc3b_word d2);
      int   acc = 0;
      int   cnt = 0;
      int   guard = 0;
      acc_t c;
      obs_n = 0; low_cnt = 0; unstable = 1'b0;
      @(negedge clk);
      start = 1'b1; opcode = op; addr = a; wdata = wd;
      @(negedge clk);
      start = 1'b0;
      opcode = lc3b_opcode'($urandom_range(0, 15)); addr = lc3b_word'($urandom); wdata = lc3b_word'($urandom);
      while (guard < 100) begin
         mif.mem_resp = 1'b0;
         mif.mem_rdata = lc3b_word'($urandom);
         if (ready) break;
         guard++;
         low_cnt++;
         c = cur_bus();
         if (acc < 4) begin
            if (cnt == 0) begin
               obs[acc] = c;
               obs_n = acc + 1;
            end else if (c != obs[acc]) begin
               unstable = 1'b1;
            end
         end
         if (cnt == ((acc == 0) ? k1 : k2)) begin
            mif.mem_resp = 1'b1;
            mif.mem_rdata = (acc == 0) ? d1 : d2;
            acc++;
            cnt = 0;
         end else begin
            cnt++;
         end
         @(negedge clk);
      end
      if (guard >= 100) check("txn_timeout", 1, 0);
   endtask

   // Expected behaviour computed from the instruction's memory semantics.
   task automatic model_check(input string tag, input lc3b_opcode op, input lc3b_word a,
                              input lc3b_word wd, input int k1, input lc3b_word d1,
                              input int k2, input lc3b_word d2);
      acc_t     e[2];
      int       n = 0;
      lc3b_word wa = {a[15:1], 1'b0};
      lc3b_word pa = {d1[15:1], 1'b0};
      logic [7:0] b = a[0] ? d1[15:8] : d1[7:0];
      lc3b_mem_wmask lane = a[0] ? 2'b10 : 2'b01;
      case (op)
         op_ldr: begin n = 1; e[0] = '{1'b1, 1'b0, wa, 2'b11, 16'h0}; m_rdata = d1; end
         op_ldb: begin n = 1; e[0] = '{1'b1, 1'b0, a, lane, 16'h0}; m_rdata = {{8{b[7]}}, b}; end
         op_str: begin n = 1; e[0] = '{1'b0, 1'b1, wa, 2'b11, wd}; end
         op_stb: begin n = 1; e[0] = '{1'b0, 1'b1, a, lane, {wd[7:0], wd[7:0]}}; end
         op_ldi: begin
            n = 2; e[0] = '{1'b1, 1'b0, wa, 2'b11, 16'h0}; e[1] = '{1'b1, 1'b0, pa, 2'b11, 16'h0};
            m_rdata = d2;
         end
         op_sti: begin
            n = 2; e[0] = '{1'b1, 1'b0, wa, 2'b11, 16'h0}; e[1] = '{1'b0, 1'b1, pa, 2'b11, wd};
         end
         default: n = 0;
      endcase
      check({tag, ".n_access"}, obs_n, n);
      check({tag, ".ready_low"}, low_cnt, (n == 0) ? 0 : ((n == 1) ? k1 + 1 : k1 + k2 + 2));
      check({tag, ".stable"}, unstable, 0);
      for (int i = 0; i < n && i < obs_n; i++) begin
         check($sformatf("%s.rd%0d", tag, i), obs[i].rd, e[i].rd);
         check($sformatf("%s.wr%0d", tag, i), obs[i].wr, e[i].wr);
         check($sformatf("%s.addr%0d", tag, i), obs[i].ad, e[i].ad);
         if (op != op_ldb) check($sformatf("%s.be%0d", tag, i), obs[i].be, e[i].be);
         if (e[i].wr) check($sformatf("%s.wdata%0d", tag, i), obs[i].wd, e[i].wd);
      end
      check({tag, ".rdata_out"}, rdata_out, m_rdata);
      check({tag, ".idle_rd"}, mif.mem_read, 0);
      check({tag, ".idle_wr"}, mif.mem_write, 0);
   endtask

   vec_t vecs[10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{op_ldr, 16'h1235, 16'h0000, 2, 16'hBEEF, 0, 16'h0000, 16'hBEEF, 3};
      vecs[1] = '{op_ldb, 16'h2001, 16'h0000, 0, 16'h80FF, 0, 16'h0000, 16'hFF80, 1};
      vecs[2] = '{op_ldb, 16'h2000, 16'h0000, 0, 16'h80FF, 0, 16'h0000, 16'hFFFF, 1};
      vecs[3] = '{op_ldb, 16'h2001, 16'h0000, 0, 16'h7F00, 0, 16'h0000, 16'h007F, 1};
      vecs[4] = '{op_stb, 16'h3003, 16'h12AB, 1, 16'h0000, 0, 16'h0000, 16'h007F, 2};
      vecs[5] = '{op_ldi, 16'h4000, 16'h0000, 1, 16'h5001, 0, 16'h1357, 16'h1357, 3};
      vecs[6] = '{op_sti, 16'h4000, 16'h2468, 0, 16'h5001, 2, 16'h0000, 16'h1357, 4};
      vecs[7] = '{op_add, 16'h1111, 16'h2222, 0, 16'h0000, 0, 16'h0000, 16'h1357, 0};
      vecs[8] = '{op_str, 16'h0101, 16'hBEEF, 0, 16'h0000, 0, 16'h0000, 16'h1357, 1};
      vecs[9] = '{op_ldi, 16'h0010, 16'h0000, 0, 16'h0001, 0, 16'hA5A5, 16'hA5A5, 2};

      mif.mem_resp = 1'b0;
      mif.mem_rdata = '0;
      m_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst.ready", ready, 1);
      check("rst.mem_read", mif.mem_read, 0);
      check("rst.mem_write", mif.mem_write, 0);
      check("rst.mem_address", mif.mem_address, 0);
      check("rst.mem_wdata", mif.mem_wdata, 0);
      check("rst.mem_byte_enable", mif.mem_byte_enable, 0);
      check("rst.rdata_out", rdata_out, 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         run_txn(vecs[i].op, vecs[i].a, vecs[i].wd, vecs[i].k1, vecs[i].d1, vecs[i].k2, vecs[i].d2);
         check($sformatf("vec%0d.table_rdata", i), rdata_out, vecs[i].exp_rdata);
         check($sformatf("vec%0d.table_low", i), low_cnt, vecs[i].exp_low);
         model_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].wd,
                     vecs[i].k1, vecs[i].d1, vecs[i].k2, vecs[i].d2);
      end

      // start pulsed while an access is outstanding
      @(negedge clk);
      start = 1'b1; opcode = op_ldr; addr = 16'h1000; wdata = 16'h0;
      @(negedge clk);
      start = 1'b1; opcode = op_str; addr = 16'h7777; wdata = 16'h5555;
      check("busy_start.rd_before", mif.mem_read, 1);
      @(negedge clk);
      start = 1'b0;
      check("busy_start.addr", mif.mem_address, 16'h1000);
      check("busy_start.rd", mif.mem_read, 1);
      check("busy_start.wr", mif.mem_write, 0);
      check("busy_start.ready", ready, 0);
      mif.mem_resp = 1'b1; mif.mem_rdata = 16'h4321;
      @(negedge clk);
      mif.mem_resp = 1'b0;
      check("busy_start.done_ready", ready, 1);
      check("busy_start.rdata_out", rdata_out, 16'h4321);
      @(negedge clk);
      check("busy_start.no_relaunch", ready, 1);
      check("busy_start.no_write", mif.mem_write, 0);
      m_rdata = 16'h4321;

      // mem_resp while idle
      mif.mem_resp = 1'b1; mif.mem_rdata = 16'h9999;
      repeat (2) @(negedge clk);
      mif.mem_resp = 1'b0;
      check("idle_resp.ready", ready, 1);
      check("idle_resp.rd", mif.mem_read, 0);
      check("idle_resp.wr", mif.mem_write, 0);
      check("idle_resp.rdata_out", rdata_out, 16'h4321);

      // reset during the indirect access of LDI
      start = 1'b1; opcode = op_ldi; addr = 16'h0200;
      @(negedge clk);
      start = 1'b0;
      mif.mem_resp = 1'b1; mif.mem_rdata = 16'h0ABD;
      @(negedge clk);
      mif.mem_resp = 1'b0;
      check("rst_ind.rd", mif.mem_read, 1);
      check("rst_ind.addr", mif.mem_address, 16'h0ABC);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_ind.ready", ready, 1);
      check("rst_ind.rd_off", mif.mem_read, 0);
      check("rst_ind.rdata_out", rdata_out, 0);
      m_rdata = '0;

      // randomized transactions against the model
      for (int t = 0; t < 40; t++) begin
         lc3b_opcode op = lc3b_opcode'($urandom_range(0, 15));
         lc3b_word   a  = lc3b_word'($urandom);
         lc3b_word   wd = lc3b_word'($urandom);
         int         k1 = $urandom_range(0, 3);
         int         k2 = $urandom_range(0, 3);
         lc3b_word   d1 = lc3b_word'($urandom);
         lc3b_word   d2 = lc3b_word'($urandom);
         run_txn(op, a, wd, k1, d1, k2, d2);
         model_check($sformatf("rnd%0d", t), op, a, wd, k1, d1, k2, d2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
